// File: rtl/io_map_pkg.sv
// Port-A I/O map shared by the switch input port and the CPU memory decoder:
// register addresses, status bit positions and the switch event payload.
package io_map_pkg;

  localparam int unsigned IO_ADDR_W = 16;

  localparam logic [IO_ADDR_W-1:0] SW_DATA_ADDR = 16'hCFFD;
  localparam logic [IO_ADDR_W-1:0] LEDS_ADDR    = 16'hCFFE;
  localparam logic [IO_ADDR_W-1:0] SW_STAT_ADDR = 16'hCFFF;
  localparam logic [IO_ADDR_W-1:0] SW_EVT_ADDR  = 16'hD000;

  localparam int unsigned STAT_NONEMPTY = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_OVF      = 2;
  localparam int unsigned STAT_IRQEN    = 3;
  localparam int unsigned STAT_CNT_LSB  = 4;
  localparam int unsigned STAT_CNT_W    = 3;

  localparam int unsigned SW_W       = 8;
  localparam int unsigned EVT_MASK_W = 8;
  localparam int unsigned EVT_VAL_W  = 8;

  typedef struct packed {
    logic [EVT_MASK_W-1:0] mask;
    logic [EVT_VAL_W-1:0]  value;
  } sw_event_t;

  localparam int unsigned EVT_W = $bits(sw_event_t);

endpackage

// File: rtl/sw_event_fifo.sv
// Small event FIFO for the switch port; resolves simultaneous push/pop,
// including push-while-full with a pop, and flags pushes it had to drop.
module sw_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop_c;
  logic             do_push_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
  assign do_pop_c  = pop_i & ~empty_o;
  assign do_push_c = push_i & (~full_o | do_pop_c);
  assign drop_c    = push_i & full_o & ~do_pop_c;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_push_c && !do_pop_c)      count_d = count_q + CNT_W'(1);
    else if (do_pop_c && !do_push_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_push_c) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sw_input_port.sv
// Memory-mapped switch input port: sync, debounce, event FIFO, status and irq.
// SW_PORT_IRQ_EN enables the irq_en status bit and the irq output.
module sw_input_port
  import io_map_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW_W-1:0]       switches,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rden,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  irq
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]       s1_q, s2_q;
  logic [SW_W-1:0]       cand_q, cand_d;
  logic [SW_W-1:0]       stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] stat_c;
  logic                  commit_c, push_c, pop_c, drop_c, stat_wr_c;
  logic                  sel_data_c, sel_stat_c, sel_evt_c;
  logic                  irq_en_c;
  sw_event_t             evt_c, head_c;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  unused_c;

  assign unused_c = ^data_in;

  assign sel_data_c = (address == ADDR_WIDTH'(SW_DATA_ADDR));
  assign sel_stat_c = (address == ADDR_WIDTH'(SW_STAT_ADDR));
  assign sel_evt_c  = (address == ADDR_WIDTH'(SW_EVT_ADDR));
  assign hit        = sel_data_c | sel_stat_c | sel_evt_c;
  assign stat_wr_c  = wren & sel_stat_c;
  assign pop_c      = rden & ~wren & sel_evt_c & ~fifo_empty;

  // Debounce: a candidate must hold for DEBOUNCE_CYCLES before it commits.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    primed_d = primed_q;
    commit_c = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX && cand_q != stable_q) begin
      commit_c = 1'b1;
      stable_d = cand_q;
      primed_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The first commit after reset only establishes the baseline level.
  assign push_c = commit_c & primed_q;
  assign evt_c  = '{mask: cand_q ^ stable_q, value: cand_q};

  sw_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (evt_c),
    .head_o  (head_c),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_c  (drop_c)
  );

  // A dropped event outranks a same-cycle clear so the loss stays visible.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr_c && data_in[STAT_OVF]) ovf_d = 1'b0;
    if (drop_c)                         ovf_d = 1'b1;
  end

  always_comb begin
    stat_c                                = '0;
    stat_c[STAT_NONEMPTY]                 = ~fifo_empty;
    stat_c[STAT_FULL]                     = fifo_full;
    stat_c[STAT_OVF]                      = ovf_q;
    stat_c[STAT_IRQEN]                    = irq_en_c;
    stat_c[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
  end

  always_comb begin
    q_d = '0;
    if (sel_data_c)                    q_d = DATA_WIDTH'(stable_q);
    else if (sel_stat_c)               q_d = stat_c;
    else if (sel_evt_c && !fifo_empty) q_d = DATA_WIDTH'(head_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
      q_q      <= '0;
    end else begin
      s1_q     <= switches;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
      q_q      <= q_d;
    end
  end

  assign q = q_q;

`ifdef SW_PORT_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (stat_wr_c) irq_en_d = data_in[STAT_IRQEN];
    irq_d = irq_en_q & (~fifo_empty | ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_c = irq_en_q;
  assign irq      = irq_q;
`else
  assign irq_en_c = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_sw_input_port.sv
// Bench for sw_input_port: window/queue reference model checked every cycle,
// plus directed register reads with hand-computed values.
module tb_sw_input_port;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] A_DATA = 16'hCFFD;
  localparam logic [15:0] A_STAT = 16'hCFFF;
  localparam logic [15:0] A_EVT  = 16'hD000;
  localparam logic [15:0] A_IDLE = 16'h0000;
`ifdef SW_PORT_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switches;
  logic [15:0] address;
  logic        wren;
  logic [15:0] data_in;
  logic        rden;
  logic        hit;
  logic [15:0] q;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  sw_input_port #(
    .DATA_WIDTH      (16),
    .ADDR_WIDTH      (16),
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .address  (address),
    .wren     (wren),
    .data_in  (data_in),
    .rden     (rden),
    .hit      (hit),
    .q        (q),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: hist[k] holds the switch level sampled k+1 edges ago.
  logic [7:0]  hist [DEB+2];
  logic [7:0]  m_stable = 8'h00;
  bit          m_primed = 1'b0;
  bit          m_irq_en = 1'b0;
  bit          m_ovf    = 1'b0;
  logic [15:0] fifo_m [$];
  logic [15:0] exp_q    = 16'h0000;
  logic        exp_irq  = 1'b0;
  bit          started  = 1'b0;
  logic [7:0]  cv;
  bit          all_eq;
  bit          m_pop;

  function automatic logic [15:0] m_stat();
    logic [2:0] c = 3'(fifo_m.size());
    return {9'b0, c, m_irq_en, m_ovf, fifo_m.size() == DEPTH, fifo_m.size() != 0};
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a == A_DATA) return {8'h00, m_stable};
    if (a == A_STAT) return m_stat();
    if (a == A_EVT)  return (fifo_m.size() != 0) ? fifo_m[0] : 16'h0000;
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      exp_q    = 16'h0000;
      exp_irq  = 1'b0;
      m_stable = 8'h00;
      m_primed = 1'b0;
      m_irq_en = 1'b0;
      m_ovf    = 1'b0;
      fifo_m.delete();
      for (int k = 0; k < DEB + 2; k++) hist[k] = 8'h00;
    end else begin
      exp_q   = m_read(address);
      exp_irq = m_irq_en && (fifo_m.size() != 0 || m_ovf);
      // A level commits once it has been seen on DEB+1 consecutive samples.
      cv     = hist[1];
      all_eq = 1'b1;
      for (int k = 1; k <= DEB + 1; k++) if (hist[k] != cv) all_eq = 1'b0;
      m_pop = rden && !wren && address == A_EVT && fifo_m.size() != 0;
      if (wren && address == A_STAT) begin
        if (IRQ_BUILD) m_irq_en = data_in[3];
        if (data_in[2]) m_ovf = 1'b0;
      end
      if (m_pop) void'(fifo_m.pop_front());
      if (all_eq && cv != m_stable) begin
        if (m_primed) begin
          if (fifo_m.size() < DEPTH) fifo_m.push_back({cv ^ m_stable, cv});
          else m_ovf = 1'b1;
        end
        m_stable = cv;
        m_primed = 1'b1;
      end
      for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = switches;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("q_model", q, exp_q);
      check("irq_model", {15'b0, irq}, {15'b0, exp_irq});
      check("hit_model", {15'b0, hit},
            {15'b0, (address == A_DATA || address == A_STAT || address == A_EVT)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [15:0] a, input logic pop, input logic [15:0] exp, input string name);
    address = a;
    rden    = pop;
    tick();
    check(name, q, exp);
    address = A_IDLE;
    rden    = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a;
    wren    = 1'b1;
    data_in = d;
    tick();
    address = A_IDLE;
    wren    = 1'b0;
    data_in = 16'h0000;
  endtask

  task automatic change(input logic [7:0] v);
    switches = v;
    repeat (9) tick();
  endtask

  initial begin
    reset    = 1'b0;
    switches = 8'h5A;
    address  = A_IDLE;
    wren     = 1'b0;
    rden     = 1'b0;
    data_in  = 16'h0000;
    repeat (3) tick();
    reset = 1'b1;
    repeat (12) tick();

    // Reset and priming
    rd(A_DATA, 1'b0, 16'h005A, "reset_data");
    rd(A_STAT, 1'b0, 16'h0000, "reset_stat");
    check("reset_irq", {15'b0, irq}, 16'h0000);
    rd(A_EVT, 1'b1, 16'h0000, "reset_evt_empty");

    // Single change: commit lands on the 7th edge after the switch moves
    switches = 8'h5B;
    address  = A_STAT;
    repeat (7) tick();
    check("single_pre", q, 16'h0000);
    tick();
    check("single_stat", q, 16'h0011);
    address = A_IDLE;
    rd(A_EVT, 1'b1, 16'h015B, "single_evt");
    rd(A_STAT, 1'b0, 16'h0000, "single_stat_after");

    // Bounce rejection around stable 0x00
    change(8'h00);
    rd(A_EVT, 1'b1, 16'h5B00, "clear_evt");
    for (int i = 0; i < 10; i++) begin
      switches[0] = ~switches[0];
      rd(A_STAT, 1'b0, 16'h0000, "bounce_stat");
      tick();
    end
    switches = 8'h01;
    repeat (9) tick();
    rd(A_STAT, 1'b0, 16'h0011, "bounce_stat_one");
    rd(A_EVT, 1'b1, 16'h0101, "bounce_evt");
    rd(A_STAT, 1'b0, 16'h0000, "bounce_stat_empty");

    // Overflow
    change(8'h03);
    change(8'h07);
    change(8'h0F);
    change(8'h1F);
    change(8'h3F);
    rd(A_STAT, 1'b0, 16'h0047, "ovf_stat");
    wr(A_STAT, 16'h0004);
    rd(A_STAT, 1'b0, 16'h0043, "ovf_cleared");
    rd(A_EVT, 1'b1, 16'h0203, "ovf_drain0");
    rd(A_EVT, 1'b1, 16'h0407, "ovf_drain1");
    rd(A_EVT, 1'b1, 16'h080F, "ovf_drain2");
    rd(A_EVT, 1'b1, 16'h101F, "ovf_drain3");
    rd(A_STAT, 1'b0, 16'h0000, "ovf_empty");

    // Full FIFO with push and pop on the same edge
    change(8'h7F);
    change(8'hFF);
    change(8'hFE);
    change(8'hFC);
    rd(A_STAT, 1'b0, 16'h0043, "full_stat");
    switches = 8'hF8;
    repeat (6) tick();
    rd(A_EVT, 1'b1, 16'h407F, "full_pushpop_evt");
    rd(A_STAT, 1'b0, 16'h0043, "full_pushpop_stat");
    rd(A_EVT, 1'b1, 16'h80FF, "full_drain0");
    rd(A_EVT, 1'b1, 16'h01FE, "full_drain1");
    rd(A_EVT, 1'b1, 16'h02FC, "full_drain2");
    rd(A_EVT, 1'b1, 16'h04F8, "full_drain3");

    // Interrupt
    wr(A_STAT, 16'h0008);
    switches = 8'hF0;
    repeat (7) tick();
    check("irq_pre", {15'b0, irq}, 16'h0000);
    tick();
    check("irq_rise", {15'b0, irq}, {15'b0, IRQ_BUILD});
    rd(A_STAT, 1'b0, IRQ_BUILD ? 16'h0019 : 16'h0011, "irq_stat");
    rd(A_EVT, 1'b1, 16'h08F0, "irq_evt");
    check("irq_hold", {15'b0, irq}, {15'b0, IRQ_BUILD});
    tick();
    check("irq_fall", {15'b0, irq}, 16'h0000);

    // One entry with push and pop on the same edge
    change(8'hE0);
    switches = 8'hC0;
    repeat (6) tick();
    rd(A_EVT, 1'b1, 16'h10E0, "one_pushpop_evt");
    rd(A_STAT, 1'b0, IRQ_BUILD ? 16'h0019 : 16'h0011, "one_pushpop_stat");
    rd(A_EVT, 1'b1, 16'h20C0, "one_pushpop_new");
    tick();
    rd(A_STAT, 1'b0, IRQ_BUILD ? 16'h0008 : 16'h0000, "irq_en_kept");

    // Reset in the middle of a debounce re-primes from scratch
    switches = 8'h33;
    repeat (4) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    rd(A_DATA, 1'b0, 16'h0033, "rearm_data");
    rd(A_STAT, 1'b0, 16'h0000, "rearm_stat");
    check("rearm_irq", {15'b0, irq}, 16'h0000);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
